// File: rtl/system_types.sv
// -----------------------------------------------------------------------------
// system_types
// Shared definitions for the system responder:
//   - system_header_t : 8-bit message header codes
//   - resp_state_t    : responder FSM states
//   - payload byte-field offsets and response payload builders
// No ports (package).
// -----------------------------------------------------------------------------
package system_types;

  typedef enum logic [7:0] {
    S_NOPE                         = 8'h00,
    S_HEARTBEAT                    = 8'h01,
    S_PARENT_REQUEST_FROM_NEIGHBOR = 8'h02,
    S_PARENT_ACK_FROM_NEIGHBOR     = 8'h03,
    S_JOIN_REQUEST                 = 8'h04,
    S_JOIN_ACK                     = 8'h05,
    S_SEARCH_FUNCTION              = 8'h06,
    S_SEARCH_FUNCTION_ACK          = 8'h07,
    S_RESET                        = 8'h08,
    S_DEBUG                        = 8'h09
  } system_header_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_RESP   = 2'd2
  } resp_state_t;

  // Payload is addressed as byte fields counted from the MSB end.
  localparam int FLD0_LSB = 56;  // [63:56]
  localparam int FLD1_LSB = 48;  // [55:48]
  localparam int FLD2_LSB = 40;  // [47:40]

  // Child slot index width; covers up to 16 slots.
  localparam int SLOT_W = 4;

  function automatic logic [7:0] get_field(input logic [63:0] p, input int lsb);
    return p[lsb +: 8];
  endfunction

  // Every response carries at most three leading bytes; the rest is zero.
  function automatic logic [63:0] build_payload(input logic [7:0] b0,
                                                input logic [7:0] b1,
                                                input logic [7:0] b2);
    return {b0, b1, b2, 40'h0};
  endfunction

  function automatic logic [63:0] parent_ack_payload(input logic [7:0] self_id,
                                                     input logic [7:0] global_id);
    return build_payload(self_id, 8'h00, global_id);
  endfunction

  function automatic logic [63:0] join_ack_payload(input logic [7:0] rand_id,
                                                   input logic [7:0] self_id,
                                                   input logic [7:0] child_id);
    return build_payload(rand_id, self_id, child_id);
  endfunction

  function automatic logic [63:0] search_ack_payload(input logic [7:0] self_id,
                                                     input logic [7:0] flit_num);
    return build_payload(self_id, flit_num, 8'h00);
  endfunction

  function automatic logic [63:0] debug_payload(input logic [7:0] self_id,
                                                input logic [7:0] rx_byte0);
    return build_payload(self_id, rx_byte0, 8'h00);
  endfunction

endpackage

// File: rtl/system_child_table.sv
// -----------------------------------------------------------------------------
// system_child_table
// Tracks which child slots are in use and the random ID that claimed each one.
// Lookup is fully parallel (CAM style); the lowest free slot is reported for
// allocation. Table updates take effect on the next rising clock edge.
//
// Parameters:
//   MAX_CHILDREN : number of slots (1..16)
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset, empties the table
//   lookup_id  in   random child ID to search for / store
//   alloc_en   in   claim the lowest free slot for lookup_id (ignored on hit)
//   clear_en   in   invalidate all slots (wins over alloc_en)
//   hit        out  lookup_id is held by a valid slot
//   hit_slot   out  index of that slot
//   free_found out  at least one slot is free
//   free_slot  out  lowest free slot index
// -----------------------------------------------------------------------------
module system_child_table
  import system_types::*;
#(
  parameter int MAX_CHILDREN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        lookup_id,
  input  logic              alloc_en,
  input  logic              clear_en,
  output logic              hit,
  output logic [SLOT_W-1:0] hit_slot,
  output logic              free_found,
  output logic [SLOT_W-1:0] free_slot
);

  logic [MAX_CHILDREN-1:0]      valid_q;
  logic [MAX_CHILDREN-1:0]      valid_d;
  logic [MAX_CHILDREN-1:0][7:0] rid_q;
  logic [MAX_CHILDREN-1:0][7:0] rid_d;
  logic [MAX_CHILDREN-1:0]      match;
  logic                         do_alloc;

  generate
    for (genvar gi = 0; gi < MAX_CHILDREN; gi++) begin : g_match
      assign match[gi] = valid_q[gi] && (rid_q[gi] == lookup_id);
    end
  endgenerate

  // At most one slot can match (an ID is never stored twice), so the
  // encoder only needs to pick any set bit; scanning downward keeps it
  // identical in shape to the free-slot encoder.
  always_comb begin
    hit      = 1'b0;
    hit_slot = '0;
    for (int i = MAX_CHILDREN - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit      = 1'b1;
        hit_slot = SLOT_W'(i);
      end
    end
  end

  // Downward scan leaves the lowest free index in free_slot.
  always_comb begin
    free_found = 1'b0;
    free_slot  = '0;
    for (int i = MAX_CHILDREN - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_slot  = SLOT_W'(i);
      end
    end
  end

  assign do_alloc = alloc_en && !hit && free_found;

  always_comb begin
    valid_d = valid_q;
    rid_d   = rid_q;
    if (clear_en) begin
      valid_d = '0;
    end else if (do_alloc) begin
      for (int i = 0; i < MAX_CHILDREN; i++) begin
        if (free_slot == SLOT_W'(i)) begin
          valid_d[i] = 1'b1;
          rid_d[i]   = lookup_id;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rid_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rid_q   <= rid_d;
    end
  end

endmodule

// File: rtl/system_responder.sv
// -----------------------------------------------------------------------------
// system_responder
// Accepts one system request at a time, decodes it for one cycle and, when a
// response applies, holds it on the tx side until accepted. Join requests
// allocate child IDs from a child_base-relative slot table.
//
// Build option: define SYSTEM_RESPONDER_DEBUG_EN to answer S_DEBUG requests
// addressed to this node; otherwise S_DEBUG is consumed silently.
//
// Parameters:
//   MAX_CHILDREN      : child slots (1..16)
//   FUNCTION_FLIT_NUM : flit count reported in search-function acks
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   self_id, global_id, child_base,
//   function_id                     node configuration (quasi-static)
//   joined                          node attached to tree; gates all acks
//   rx_valid/rx_ready/rx_header/
//   rx_payload                      inbound request handshake
//   tx_valid/tx_ready/tx_header/
//   tx_payload                      outbound response handshake
//   join_reject                     pulse when a join is dropped (table full)
// -----------------------------------------------------------------------------
module system_responder
  import system_types::*;
#(
  parameter int         MAX_CHILDREN      = 8,
  parameter logic [7:0] FUNCTION_FLIT_NUM = 8'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  self_id,
  input  logic [7:0]  global_id,
  input  logic [7:0]  child_base,
  input  logic [7:0]  function_id,
  input  logic        joined,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_header,
  input  logic [63:0] rx_payload,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_header,
  output logic [63:0] tx_payload,
  output logic        join_reject
);

  resp_state_t    state_q, state_d;
  system_header_t hdr_q, hdr_d;
  logic [63:0]    pay_q, pay_d;
  system_header_t tx_hdr_q, tx_hdr_d;
  logic [63:0]    tx_pay_q, tx_pay_d;

  logic              tbl_alloc;
  logic              tbl_clear;
  logic              tbl_hit;
  logic [SLOT_W-1:0] tbl_hit_slot;
  logic              tbl_free_found;
  logic [SLOT_W-1:0] tbl_free_slot;
  logic [7:0]        child_id;

  logic              respond;
  system_header_t    resp_hdr;
  logic [63:0]       resp_pay;

  logic [7:0] rx_b0;
  logic [7:0] rx_b1;

  assign rx_b0 = get_field(pay_q, FLD0_LSB);
  assign rx_b1 = get_field(pay_q, FLD1_LSB);

  system_child_table #(
    .MAX_CHILDREN(MAX_CHILDREN)
  ) u_child_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_id  (rx_b0),
    .alloc_en   (tbl_alloc),
    .clear_en   (tbl_clear),
    .hit        (tbl_hit),
    .hit_slot   (tbl_hit_slot),
    .free_found (tbl_free_found),
    .free_slot  (tbl_free_slot)
  );

  // A returning child keeps its slot; a new one gets the lowest free slot.
  // The 8-bit add wraps naturally past 8'hFF.
  assign child_id = tbl_hit ? (child_base + {{(8-SLOT_W){1'b0}}, tbl_hit_slot})
                            : (child_base + {{(8-SLOT_W){1'b0}}, tbl_free_slot});

  // Gating with rst_n keeps rx_ready low while reset is held.
  assign rx_ready    = rst_n && (state_q == ST_IDLE);
  assign tx_valid    = (state_q == ST_RESP);
  assign tx_header   = tx_hdr_q;
  assign tx_payload  = tx_pay_q;

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    pay_d       = pay_q;
    tx_hdr_d    = tx_hdr_q;
    tx_pay_d    = tx_pay_q;
    tbl_alloc   = 1'b0;
    tbl_clear   = 1'b0;
    join_reject = 1'b0;
    respond     = 1'b0;
    resp_hdr    = S_NOPE;
    resp_pay    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          hdr_d   = system_header_t'(rx_header);
          pay_d   = rx_payload;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        case (hdr_q)
          S_PARENT_REQUEST_FROM_NEIGHBOR: begin
            if (joined) begin
              respond  = 1'b1;
              resp_hdr = S_PARENT_ACK_FROM_NEIGHBOR;
              resp_pay = parent_ack_payload(self_id, global_id);
            end
          end

          S_JOIN_REQUEST: begin
            if (joined && (rx_b1 == self_id)) begin
              if (tbl_hit || tbl_free_found) begin
                respond   = 1'b1;
                resp_hdr  = S_JOIN_ACK;
                resp_pay  = join_ack_payload(rx_b0, self_id, child_id);
                tbl_alloc = !tbl_hit;
              end else begin
                join_reject = 1'b1;
              end
            end
          end

          S_SEARCH_FUNCTION: begin
            if (joined && (rx_b0 == function_id)) begin
              respond  = 1'b1;
              resp_hdr = S_SEARCH_FUNCTION_ACK;
              resp_pay = search_ack_payload(self_id, FUNCTION_FLIT_NUM);
            end
          end

          S_RESET: begin
            tbl_clear = 1'b1;
          end

`ifdef SYSTEM_RESPONDER_DEBUG_EN
          // Debug is a diagnostic path, not a tree ack, so it is not gated
          // by joined.
          S_DEBUG: begin
            if (rx_b1 == self_id) begin
              respond  = 1'b1;
              resp_hdr = S_DEBUG;
              resp_pay = debug_payload(self_id, rx_b0);
            end
          end
`endif

          default: begin
            // Heartbeats, acks, no-ops and unknown codes are consumed.
          end
        endcase

        if (respond) begin
          tx_hdr_d = resp_hdr;
          tx_pay_d = resp_pay;
          state_d  = ST_RESP;
        end else begin
          state_d  = ST_IDLE;
        end
      end

      ST_RESP: begin
        if (tx_ready) begin
          state_d  = ST_IDLE;
          tx_hdr_d = S_NOPE;
          tx_pay_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      hdr_q    <= S_NOPE;
      pay_q    <= '0;
      tx_hdr_q <= S_NOPE;
      tx_pay_q <= '0;
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      pay_q    <= pay_d;
      tx_hdr_q <= tx_hdr_d;
      tx_pay_q <= tx_pay_d;
    end
  end

endmodule

// File: tb/tb_system_responder.sv
// -----------------------------------------------------------------------------
// tb_system_responder
// Drives directed and randomized requests into system_responder and compares
// every cycle against a transaction-level model of the responder.
// -----------------------------------------------------------------------------
module tb_system_responder;
  import system_types::*;

  localparam int         MC   = 2;
  localparam logic [7:0] FLIT = 8'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  self_id, global_id, child_base, function_id;
  logic        joined;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_header;
  logic [63:0] rx_payload;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_header;
  logic [63:0] tx_payload;
  logic        join_reject;

  always #5 clk = ~clk;

  system_responder #(
    .MAX_CHILDREN      (MC),
    .FUNCTION_FLIT_NUM (FLIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .self_id     (self_id),
    .global_id   (global_id),
    .child_base  (child_base),
    .function_id (function_id),
    .joined      (joined),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_header   (rx_header),
    .rx_payload  (rx_payload),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_header   (tx_header),
    .tx_payload  (tx_payload),
    .join_reject (join_reject)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // The model tracks one outstanding request: its age in cycles since the
  // transfer, whether it produces a response and what that response is.
  bit          m_busy = 1'b0;
  int          m_age  = 0;
  bit          m_has  = 1'b0;
  bit          m_rej  = 1'b0;
  logic [7:0]  m_hdr;
  logic [63:0] m_pay;
  bit          used [16];
  int          slot_of [int];

  int          tx_count  = 0;
  int          rej_count = 0;
  logic [7:0]  last_hdr  = 8'h00;
  logic [63:0] last_pay  = 64'h0;

  task automatic table_clear();
    for (int i = 0; i < 16; i++) used[i] = 1'b0;
    slot_of.delete();
  endtask

  task automatic model_request(input logic [7:0] h, input logic [63:0] p);
    int rid;
    int s;
    m_has = 1'b0;
    m_rej = 1'b0;
    m_hdr = S_NOPE;
    m_pay = 64'h0;
    rid   = int'(p[63:56]);
    s     = -1;
    case (h)
      S_PARENT_REQUEST_FROM_NEIGHBOR: begin
        if (joined) begin
          m_has = 1'b1;
          m_hdr = S_PARENT_ACK_FROM_NEIGHBOR;
          m_pay = {self_id, 8'h00, global_id, 40'h0};
        end
      end
      S_JOIN_REQUEST: begin
        if (joined && p[55:48] == self_id) begin
          if (slot_of.exists(rid)) begin
            s = slot_of[rid];
          end else begin
            for (int i = 0; i < MC; i++) if (!used[i] && s < 0) s = i;
            if (s >= 0) begin
              used[s]      = 1'b1;
              slot_of[rid] = s;
            end
          end
          if (s < 0) begin
            m_rej = 1'b1;
          end else begin
            m_has = 1'b1;
            m_hdr = S_JOIN_ACK;
            m_pay = {p[63:56], self_id, 8'(int'(child_base) + s), 40'h0};
          end
        end
      end
      S_SEARCH_FUNCTION: begin
        if (joined && p[63:56] == function_id) begin
          m_has = 1'b1;
          m_hdr = S_SEARCH_FUNCTION_ACK;
          m_pay = {self_id, FLIT, 48'h0};
        end
      end
      S_RESET: table_clear();
`ifdef SYSTEM_RESPONDER_DEBUG_EN
      S_DEBUG: begin
        if (p[55:48] == self_id) begin
          m_has = 1'b1;
          m_hdr = S_DEBUG;
          m_pay = {self_id, p[63:56], 48'h0};
        end
      end
`endif
      default: ;
    endcase
  endtask

  // ---------------- per-cycle compare process ----------------
  initial begin
    bit e_rdy, e_val, e_rej;
    table_clear();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_rx_ready",    rx_ready,    0);
        chk("rst_tx_valid",    tx_valid,    0);
        chk("rst_tx_header",   tx_header,   S_NOPE);
        chk("rst_tx_payload",  tx_payload,  0);
        chk("rst_join_reject", join_reject, 0);
        m_busy = 1'b0;
        table_clear();
      end else begin
        e_rdy = !m_busy;
        e_val = m_busy && m_has && (m_age >= 2);
        e_rej = m_busy && (m_age == 1) && m_rej;
        chk("rx_ready",    rx_ready,    e_rdy);
        chk("tx_valid",    tx_valid,    e_val);
        chk("join_reject", join_reject, e_rej);
        if (e_val) begin
          chk("tx_header",  tx_header,  m_hdr);
          chk("tx_payload", tx_payload, m_pay);
        end
        if (join_reject) rej_count++;
        if (tx_valid && tx_ready) begin
          tx_count++;
          last_hdr = tx_header;
          last_pay = tx_payload;
        end
        // What the coming clock edge does to the outstanding request.
        if (!m_busy) begin
          if (rx_valid) begin
            model_request(rx_header, rx_payload);
            m_busy = 1'b1;
            m_age  = 1;
          end
        end else if (m_age == 1 && !m_has) begin
          m_busy = 1'b0;
        end else if (m_age >= 2 && tx_ready) begin
          m_busy = 1'b0;
        end else begin
          m_age++;
        end
      end
    end
  end

  // hold < 0 : random tx_ready and random rx noise while busy
  // hold >= 0: tx_ready rises hold cycles after the transfer
  task automatic send(input logic [7:0] h, input logic [63:0] p, input int hold);
    int n;
    n = 0;
    while (m_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    rx_header  = h;
    rx_payload = p;
    rx_valid   = 1'b1;
    tx_ready   = 1'b0;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    n = 1;
    while (m_busy && n < 100) begin
      if (hold < 0) begin
        tx_ready   = ($urandom_range(0, 1) == 1);
        rx_valid   = ($urandom_range(0, 3) == 0);
        rx_header  = 8'($urandom);
        rx_payload = {$urandom, $urandom};
      end else begin
        tx_ready = (n >= hold);
      end
      @(posedge clk); #1;
      n++;
    end
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    chk("send_timeout", m_busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c, r;
    logic [7:0] h;
    logic [7:0] b0, b1;
    self_id     = 8'h10;
    global_id   = 8'h77;
    child_base  = 8'h40;
    function_id = 8'h3C;
    joined      = 1'b1;
    rx_valid    = 1'b0;
    rx_header   = 8'h00;
    rx_payload  = 64'h0;
    tx_ready    = 1'b0;

    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_rx_ready", rx_ready, 1);

    // First join with explicit latency check.
    rx_header  = S_JOIN_REQUEST;
    rx_payload = {8'hA5, 8'h10, 48'h0};
    rx_valid   = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    chk("lat_decode_tx_valid", tx_valid, 0);
    @(posedge clk); #1;
    chk("lat_resp_tx_valid", tx_valid, 1);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    chk("join_a5_hdr", last_hdr, S_JOIN_ACK);
    chk("join_a5_pay", last_pay, {8'hA5, 8'h10, 8'h40, 40'h0});

    send(S_JOIN_REQUEST, {8'hA5, 8'h10, 48'h0}, 0);
    chk("join_a5_again", last_pay, {8'hA5, 8'h10, 8'h40, 40'h0});
    send(S_JOIN_REQUEST, {8'hA6, 8'h10, 48'h0}, 0);
    chk("join_a6", last_pay, {8'hA6, 8'h10, 8'h41, 40'h0});

    c = tx_count; r = rej_count;
    send(S_JOIN_REQUEST, {8'hA7, 8'h10, 48'h0}, 0);
    chk("full_no_tx", tx_count, c);
    chk("full_reject_once", rej_count, r + 1);

    send(S_RESET, 64'h0, 0);
    send(S_JOIN_REQUEST, {8'hA7, 8'h10, 48'h0}, 0);
    chk("after_reset_slot0", last_pay, {8'hA7, 8'h10, 8'h40, 40'h0});

    send(S_RESET, 64'h0, 0);
    child_base = 8'hFF;
    send(S_JOIN_REQUEST, {8'hB0, 8'h10, 48'h0}, 0);
    chk("wrap_first", last_pay, {8'hB0, 8'h10, 8'hFF, 40'h0});
    send(S_JOIN_REQUEST, {8'hB1, 8'h10, 48'h0}, 0);
    chk("wrap_second", last_pay, {8'hB1, 8'h10, 8'h00, 40'h0});
    child_base = 8'h40;

    send(S_SEARCH_FUNCTION, {8'h3C, 56'h0}, 0);
    chk("search_hdr", last_hdr, S_SEARCH_FUNCTION_ACK);
    chk("search_pay", last_pay, {8'h10, 8'h03, 48'h0});
    c = tx_count;
    send(S_SEARCH_FUNCTION, {8'h3D, 56'h0}, 0);
    chk("search_miss_no_tx", tx_count, c);
    joined = 1'b0;
    send(S_SEARCH_FUNCTION, {8'h3C, 56'h0}, 0);
    send(S_PARENT_REQUEST_FROM_NEIGHBOR, 64'h0, 0);
    chk("unjoined_no_tx", tx_count, c);
    joined = 1'b1;
    send(S_JOIN_REQUEST, {8'hA8, 8'h11, 48'h0}, 0);
    send(S_DEBUG, {8'h99, 8'h10, 48'h0}, 0);
    send(S_HEARTBEAT, 64'h1234, 0);
`ifndef SYSTEM_RESPONDER_DEBUG_EN
    chk("silent_requests_no_tx", tx_count, c);
`endif

    // Back-pressure: tx_ready low for 5 cycles of tx_valid.
    send(S_PARENT_REQUEST_FROM_NEIGHBOR, 64'hDEAD_BEEF_0000_0001, 7);
    chk("parent_hdr", last_hdr, S_PARENT_ACK_FROM_NEIGHBOR);
    chk("parent_pay", last_pay, {8'h10, 8'h00, 8'h77, 40'h0});

    // Reset while a response is pending.
    rx_header  = S_PARENT_REQUEST_FROM_NEIGHBOR;
    rx_payload = 64'h0;
    rx_valid   = 1'b1;
    tx_ready   = 1'b0;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    chk("resp_before_reset", tx_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_drops_tx_valid", tx_valid, 0);
    chk("reset_rx_ready_low", rx_ready, 0);
    c = tx_count;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tx_ready = 1'b0;
    chk("no_tx_after_reset", tx_count, c);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) == 0) joined = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 19) == 0) child_base = 8'($urandom);
      b1 = ($urandom_range(0, 3) != 0) ? self_id : 8'($urandom);
      case ($urandom_range(0, 11))
        0, 1:    h = S_PARENT_REQUEST_FROM_NEIGHBOR;
        2, 3, 4: h = S_JOIN_REQUEST;
        5, 6:    h = S_SEARCH_FUNCTION;
        7:       h = S_RESET;
        8:       h = S_DEBUG;
        9:       h = S_HEARTBEAT;
        10:      h = S_JOIN_ACK;
        default: h = 8'($urandom_range(16, 255));
      endcase
      if (h == S_SEARCH_FUNCTION)
        b0 = function_id + 8'($urandom_range(0, 1));
      else
        b0 = 8'hA0 + 8'($urandom_range(0, 3));
      send(h, {b0, b1, $urandom, 16'($urandom)}, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/system_responder.md
SYSTEM_RESPONDER -- requirements
Module: system_responder

Interface
REQ-001 SHALL have parameter MAX_CHILDREN, default 8, meaning number of child-ID slots (1..16).
REQ-002 SHALL have parameter FUNCTION_FLIT_NUM, default 8'd1, meaning flit count reported in search_function_ack.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports self_id, global_id, child_base, function_id  input  8 each  node config, quasi-static.
REQ-006 SHALL have port joined  input  1  node is attached to tree; gates all acks.
REQ-007 SHALL have ports rx_valid input 1, rx_ready output 1, rx_header input 8 (system_header_t), rx_payload input 64  inbound request.
REQ-008 SHALL have ports tx_valid output 1, tx_ready input 1, tx_header output 8, tx_payload output 64  outbound response.
REQ-009 SHALL have port join_reject  output  1  one-cycle pulse when a join is dropped for table full.

Function
REQ-010 SHALL run FSM IDLE -> DECODE -> RESP -> IDLE; rx_ready=1 only in IDLE; a request transfers when rx_valid&&rx_ready.
REQ-011 SHALL capture header/payload on transfer; DECODE (1 cycle) decides response; tx_valid rises 2 cycles after transfer.
REQ-012 SHALL hold tx_valid, tx_header, tx_payload stable in RESP until tx_ready; return to IDLE the cycle after tx_valid&&tx_ready.
REQ-013 SHALL go DECODE -> IDLE with no tx when no response applies.
REQ-014 S_PARENT_REQUEST_FROM_NEIGHBOR with joined=1 SHALL answer S_PARENT_ACK_FROM_NEIGHBOR: [63:56]=self_id, [55:48]=8'h00, [47:40]=global_id.
REQ-015 S_JOIN_REQUEST with joined=1 and payload[55:48]==self_id SHALL answer S_JOIN_ACK: [63:56]=random_child_id echoed, [55:48]=self_id, [47:40]=allocated child_id.
REQ-016 Join allocation: random_child_id already in table SHALL reuse its slot (no new slot); else lowest free slot s, child_id=child_base+s modulo 256.
REQ-017 Join with table full and no hit SHALL send nothing and pulse join_reject in DECODE.
REQ-018 S_SEARCH_FUNCTION with payload[63:56]==function_id and joined=1 SHALL answer S_SEARCH_FUNCTION_ACK: [63:56]=self_id, [55:48]=FUNCTION_FLIT_NUM.
REQ-019 S_RESET SHALL clear all table slots in DECODE and send nothing.
REQ-020 S_NOPE, S_HEARTBEAT, acks, undefined codes SHALL be consumed with no response.
REQ-021 All response payload bits not assigned above SHALL be zero.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, rx_ready=0 during reset then 1 in IDLE, tx_valid=0, tx_header=S_NOPE, tx_payload=0, join_reject=0, table empty.
REQ-023 Reset asserted during RESP SHALL drop the pending response; no tx after release.

Configuration
REQ-024 Macro SYSTEM_RESPONDER_DEBUG_EN defined: S_DEBUG with payload[55:48]==self_id SHALL answer S_DEBUG, [63:56]=self_id, [55:48]=received [63:56].
REQ-025 Macro undefined: S_DEBUG SHALL be consumed silently; no debug logic synthesized.

Structure
REQ-026 Payload field offsets, response-builder functions and responder state enum SHALL live in system_types package.
REQ-027 Child table (valid bits, random-ID CAM, hit/free-slot lookup, clear) SHALL be sub-module system_child_table.

Verification
REQ-028 self_id=8'h10, joined=1, join request {8'hA5,8'h10} -> join_ack {8'hA5,8'h10,child_base+0} at transfer+2.
REQ-029 Same 8'hA5 join repeated -> identical child_id; new 8'hA6 -> child_base+1.
REQ-030 MAX_CHILDREN=2, third distinct join -> no tx, join_reject pulses once; S_RESET then join -> slot 0 reused.
REQ-031 child_base=8'hFF, two joins -> child_ids 8'hFF then 8'h00.
REQ-032 tx_ready held low 5 cycles -> tx_* stable, rx_ready=0; rst_n low in RESP -> tx_valid=0 immediately, nothing sent after.
REQ-033 function_id=8'h3C: search 8'h3C -> ack {self_id,FUNCTION_FLIT_NUM}; search 8'h3D or joined=0 -> no tx.
